// File: rtl/twiddle_cmult_if.sv
// Handshake and operand/result bundle for the sequential complex multiplier.
// The slave modport is the multiplier side; master is the producer/consumer side.
interface twiddle_cmult_if #(
  parameter int W = 18
);
  logic                i_valid;
  logic                o_in_ready;
  logic signed [W-1:0] i_s18_ar;
  logic signed [W-1:0] i_s18_ai;
  logic signed [W-1:0] i_s18_br;
  logic signed [W-1:0] i_s18_bi;
  logic                o_valid;
  logic                i_out_ready;
  logic signed [W-1:0] o_s18_re;
  logic signed [W-1:0] o_s18_im;

  modport slave (
    input  i_valid, i_s18_ar, i_s18_ai, i_s18_br, i_s18_bi, i_out_ready,
    output o_in_ready, o_valid, o_s18_re, o_s18_im
  );

  modport master (
    output i_valid, i_s18_ar, i_s18_ai, i_s18_br, i_s18_bi, i_out_ready,
    input  o_in_ready, o_valid, o_s18_re, o_s18_im
  );
endinterface

// File: rtl/twiddle_cmult.sv
// Complex sample x Q1.17 twiddle multiply sharing one X*Y+C unit across four
// products; each accumulated result is rounded half-up and saturated to W bits.
module twiddle_cmult #(
  parameter int W     = 18,
  parameter int SHIFT = 17
) (
  input  logic clk,
  input  logic rst,
  twiddle_cmult_if.slave bus
);
  localparam int AW = 48;
  localparam logic signed [AW-1:0] RND_BIAS = 48'sd1 <<< (SHIFT - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = (48'sd1 <<< (W - 1)) - 48'sd1;
  localparam logic signed [AW-1:0] SAT_MIN  = -(48'sd1 <<< (W - 1));

  typedef enum logic [2:0] {IDLE, RE0, RE1, IM0, IM1, OUT} state_t;

  state_t state_reg, state_next;

  logic                 in_ready_reg;
  logic                 valid_reg;
  logic signed [W-1:0]  re_reg;
  logic signed [W-1:0]  im_reg;
  logic signed [AW-1:0] acc_reg;

  // Operand slots: 0 = ar, 1 = ai, 2 = br, 3 = bi.
  logic signed [W-1:0] op_in  [4];
  logic signed [W-1:0] op_reg [4];
  logic                take_op;

  assign op_in[0] = bus.i_s18_ar;
  assign op_in[1] = bus.i_s18_ai;
  assign op_in[2] = bus.i_s18_br;
  assign op_in[3] = bus.i_s18_bi;
  assign take_op  = (state_reg == IDLE) && bus.i_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_op
      always_ff @(posedge clk) begin
        if (rst) begin
          op_reg[gi] <= '0;
        end else if (take_op) begin
          op_reg[gi] <= op_in[gi];
        end
      end
    end
  endgenerate

  logic signed [W-1:0]    mac_x, mac_y;
  logic                   mac_sub, mac_use_acc;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   prod_ext, mac_c, mac_out;
  logic signed [AW-1:0]   rnd_sum, rnd_val;
  logic signed [W-1:0]    sat_val;

  always_comb begin
    state_next  = state_reg;
    mac_x       = op_reg[0];
    mac_y       = op_reg[2];
    mac_sub     = 1'b0;
    mac_use_acc = 1'b0;
    case (state_reg)
      IDLE: if (bus.i_valid) state_next = RE0;
      RE0:  state_next = RE1;
      RE1: begin
        mac_x       = op_reg[1];
        mac_y       = op_reg[3];
        mac_sub     = 1'b1;
        mac_use_acc = 1'b1;
        state_next  = IM0;
      end
      IM0: begin
        mac_y      = op_reg[3];
        state_next = IM1;
      end
      IM1: begin
        mac_x       = op_reg[1];
        mac_use_acc = 1'b1;
        state_next  = OUT;
      end
      OUT:     if (bus.i_out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is done after widening so that -(-2^(W-1)) cannot overflow.
  assign prod     = (2*W)'(mac_x) * (2*W)'(mac_y);
  assign prod_ext = AW'(prod);
  assign mac_c    = mac_use_acc ? acc_reg : '0;
  assign mac_out  = mac_sub ? (mac_c - prod_ext) : (mac_c + prod_ext);
  assign rnd_sum  = mac_out + RND_BIAS;
  assign rnd_val  = rnd_sum >>> SHIFT;

  always_comb begin
    if (rnd_val > SAT_MAX) begin
      sat_val = SAT_MAX[W-1:0];
    end else if (rnd_val < SAT_MIN) begin
      sat_val = SAT_MIN[W-1:0];
    end else begin
      sat_val = rnd_val[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b1;
      valid_reg    <= 1'b0;
      re_reg       <= '0;
      im_reg       <= '0;
      acc_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        RE0: acc_reg <= mac_out;
        RE1: re_reg  <= sat_val;
        IM0: acc_reg <= mac_out;
        IM1: begin
          im_reg    <= sat_val;
          valid_reg <= 1'b1;
        end
        OUT: if (bus.i_out_ready) valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.o_in_ready = in_ready_reg;
  assign bus.o_valid    = valid_reg;
  assign bus.o_s18_re   = re_reg;
  assign bus.o_s18_im   = im_reg;
endmodule

// File: doc/twiddle_cmult.md
# twiddle_cmult

Sequential complex multiplier for the FFT datapath. It multiplies an 18-bit signed complex sample by an 18-bit signed Q1.17 twiddle factor, time-sharing one multiply-accumulate unit (X*Y+C, 48-bit accumulator) over four products. It sits directly upstream of the butterfly adder stage and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- W, 18: operand and result width (signed, two's complement).
- SHIFT, 17: right-shift applied to the accumulated product (twiddle fractional bits).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input operands valid.
- o_in_ready  out  1  block can accept operands.
- i_s18_ar, i_s18_ai  in  W  sample real and imaginary parts.
- i_s18_br, i_s18_bi  in  W  twiddle real and imaginary parts (Q1.17).
- o_valid  out  1  result valid.
- i_out_ready  in  1  downstream accepts result.
- o_s18_re, o_s18_im  out  W  result real and imaginary parts.

## Operation
- Computes re = ar*br − ai*bi and im = ar*bi + ai*br.
- Operands are latched into internal registers on input handshake (i_valid && o_in_ready). Input ports are ignored at all other times.
- Internal accumulator is 48-bit signed. Products are sign-extended 2W-bit values.
- Rounding and saturation are applied to each accumulator result, in this order:
  - Round: add 2^(SHIFT−1), then arithmetic shift right by SHIFT. This rounds half toward +∞.
  - Saturate: clamp to [−2^(W−1), 2^(W−1)−1].
- State machine, one state per cycle:
  - IDLE: o_in_ready=1. On input handshake, latch operands → RE0.
  - RE0: acc <= ar*br → RE1.
  - RE1: re_reg <= sat(rnd(acc − ai*bi)) → IM0.
  - IM0: acc <= ar*bi → IM1.
  - IM1: im_reg <= sat(rnd(acc + ai*br)); o_valid <= 1 → OUT.
  - OUT: hold o_valid, o_s18_re and o_s18_im stable. On output handshake (o_valid && i_out_ready): o_valid <= 0 → IDLE.
- o_in_ready is 1 only in IDLE. The block never accepts a new input while a result is pending.
- i_valid may be held high continuously. Only one sample is taken per IDLE visit.
- i_out_ready may be high before o_valid. The handshake then completes on the first OUT cycle.

## Timing
- Reset values:
  - state = IDLE, o_in_ready = 1, o_valid = 0.
  - o_s18_re = 0, o_s18_im = 0, accumulator = 0.
- Reset dominates every other event. Asserting rst in any state (including mid-computation or OUT with a pending result) discards the operation. The next cycle shows the reset values, and the discarded result is never presented.
- Latency:
  - Input handshake at rising edge E → o_valid = 1 after edge E+4.
  - o_s18_re is already final after edge E+2, but is only qualified by o_valid.
- Throughput: at most one sample per 6 cycles (4 compute cycles, ≥1 OUT cycle, 1 IDLE cycle).
- Backpressure: while i_out_ready = 0, OUT holds indefinitely with all outputs unchanged.
- Outputs are registered. No combinational path from any input to any output except i_out_ready, which has no output-visible effect until the next edge.

## Test plan
- Basic real multiply: ar=65536, ai=0, br=65536, bi=0 (0.5×0.5) → o_s18_re=32768, o_s18_im=0. o_valid rises exactly 4 edges after the input handshake.
- Near-unity twiddle: ar=1000, ai=2000, br=131071, bi=0 → re=1000, im=2000. Checks round-half-up on values 999.992 and 1999.98.
- j×j: ar=0, ai=65536, br=0, bi=65536 → re=−32768, im=0. Checks the subtraction path.
- Saturation: ar=−131072, ai=0, br=−131072, bi=0 → re=131071 (clamped from 131072), im=0.
- Backpressure and hold:
  - Hold i_out_ready=0 for 10 cycles after o_valid, with i_valid=1 and new operands on the inputs throughout.
  - Outputs stay stable and o_in_ready stays 0 for the whole period.
  - After the handshake, o_in_ready=1 for exactly one IDLE cycle and the new operands are accepted.
- Reset mid-operation: assert rst for one cycle while in IM0 → next cycle o_valid=0, o_in_ready=1, outputs 0. A following sample computes correctly with no residue from the aborted operation.
